// File: rtl/imm_ext_pipe_pkg.sv
// Shared extension-op codes for the immediate-extension stage.
// Ops 4..7 are reserved and flagged as illegal by the core.
package imm_ext_pipe_pkg;

    localparam int EXT_OP_W = 3;

    typedef enum logic [EXT_OP_W-1:0] {
        EXT_ZERO    = 3'd0,
        EXT_SIGNED  = 3'd1,
        EXT_HIGHPOS = 3'd2,
        EXT_BRANCH  = 3'd3
    } ext_op_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: zero/sign extend, lui placement, branch offset.
// Requires DATA_W >= IMM_W+2 so the branch shift keeps the whole immediate.
module imm_ext_core
    import imm_ext_pipe_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic [IMM_W-1:0]    imm,
    input  logic [EXT_OP_W-1:0] op,
    output logic [DATA_W-1:0]   imm32,
    output logic                err
);

    logic [DATA_W-1:0] sext;

    assign sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

    always_comb begin
        imm32 = '0;
        err   = 1'b0;
        case (op)
            EXT_ZERO:    imm32 = {{(DATA_W-IMM_W){1'b0}}, imm};
            EXT_SIGNED:  imm32 = sext;
            EXT_HIGHPOS: imm32 = {imm, {(DATA_W-IMM_W){1'b0}}};
            EXT_BRANCH:  imm32 = sext << 2;
            default:     err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate-extension stage: output register plus one skid entry,
// valid/ready on both sides, synchronous flush and reset.
module imm_ext_pipe
    import imm_ext_pipe_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IMM_W-1:0]    in_imm,
    input  logic [EXT_OP_W-1:0] in_op,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_imm,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_err
);

    logic [DATA_W-1:0] ext_imm;
    logic              ext_err;

    logic              or_valid;
    logic [DATA_W-1:0] or_imm;
    logic [TAG_W-1:0]  or_tag;
    logic              or_err;

    logic              sk_valid;
    logic [DATA_W-1:0] sk_imm;
    logic [TAG_W-1:0]  sk_tag;
    logic              sk_err;

    logic accept;
    logic or_free;

    imm_ext_core #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W)
    ) u_core (
        .imm   (in_imm),
        .op    (in_op),
        .imm32 (ext_imm),
        .err   (ext_err)
    );

    // in_ready depends only on registered skid state, never on out_ready.
    assign in_ready = !sk_valid && !rst;
    assign accept   = in_valid && in_ready;
    assign or_free  = !or_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            or_valid <= 1'b0;
            or_imm   <= '0;
            or_tag   <= '0;
            or_err   <= 1'b0;
            sk_valid <= 1'b0;
            sk_imm   <= '0;
            sk_tag   <= '0;
            sk_err   <= 1'b0;
        end else if (flush) begin
            or_valid <= 1'b0;
            sk_valid <= 1'b0;
        end else if (or_free) begin
            // Skid entry is older than anything upstream, so it refills OR first.
            if (sk_valid) begin
                or_valid <= 1'b1;
                or_imm   <= sk_imm;
                or_tag   <= sk_tag;
                or_err   <= sk_err;
                sk_valid <= 1'b0;
            end else if (accept) begin
                or_valid <= 1'b1;
                or_imm   <= ext_imm;
                or_tag   <= in_tag;
                or_err   <= ext_err;
            end else begin
                or_valid <= 1'b0;
            end
        end else if (accept) begin
            sk_valid <= 1'b1;
            sk_imm   <= ext_imm;
            sk_tag   <= in_tag;
            sk_err   <= ext_err;
        end
    end

    assign out_valid = or_valid;
    assign out_imm   = or_imm;
    assign out_tag   = or_tag;
    assign out_err   = or_err;

endmodule
